ram_port_arbiter: RTL

- Shares the single port of the framebuffer/system RAM between two requesters: the CPU bus (picorv32-style valid/ready) and the video line-prefetch engine.
- The video prefetch engine is read-only; its CDC to clk_pixel is handled upstream in soc_video.
- Runs entirely in the clk_cpu domain and sits between the CPU interconnect, the soc_video fetch path, and the ram_memory port.
- Video has priority; a run-length guard prevents CPU starvation.

---
 rtl/ram_arb_pkg.sv | 23 ++
 rtl/ram_arb_sched.sv | 54 +++++
 rtl/ram_port_arbiter.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the RAM port arbiter (ram_port_arbiter,
// ram_arb_sched). Optional grant statistics are enabled with the
// RAM_ARB_STATS_EN macro in ram_port_arbiter.
package ram_arb_pkg;

  localparam int DATA_W = 32;
  localparam int STRB_W = 4;

  // Access sequencer: arbitrate, strobe the RAM for one cycle, return data.
  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_e;

  // Which requester owns the access currently in flight.
  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_CPU,
    GNT_VID
  } grant_e;

endpackage

// File: rtl/ram_arb_sched.sv
// Priority scheduler for the RAM port: video wins by default, but after
// VID_MAX_RUN consecutive video wins against a waiting CPU the CPU is served.
// The grant is only produced (and the run counter only moves) while
// i_arb_en-equivalent input arb_en is high, i.e. while the top is in IDLE.
module ram_arb_sched
  import ram_arb_pkg::*;
#(
  parameter int VID_MAX_RUN = 4
) (
  input  logic   clk_cpu,
  input  logic   reset,
  input  logic   cpu_valid,
  input  logic   vid_req,
  input  logic   arb_en,
  output grant_e gnt
);

  localparam logic [3:0] MAX_RUN = 4'(VID_MAX_RUN);

  // Consecutive video grants won while the CPU was also waiting.
  logic [3:0] r_run_cnt;
  logic [3:0] w_run_cnt_nxt;

  // Priority decision and next run length for the current arbitration.
  always_comb begin
    gnt           = GNT_NONE;
    w_run_cnt_nxt = r_run_cnt;
    if (arb_en) begin
      if (vid_req && cpu_valid) begin
        if (r_run_cnt < MAX_RUN) begin
          gnt           = GNT_VID;
          w_run_cnt_nxt = r_run_cnt + 4'd1;
        end else begin
          gnt           = GNT_CPU;
          w_run_cnt_nxt = 4'd0;
        end
      end else if (vid_req) begin
        // No CPU waiting, so there is no starvation to track.
        gnt           = GNT_VID;
        w_run_cnt_nxt = 4'd0;
      end else if (cpu_valid) begin
        gnt           = GNT_CPU;
        w_run_cnt_nxt = 4'd0;
      end
    end
  end

  // Run-length register.
  always_ff @(posedge clk_cpu or posedge reset) begin
    if (reset) r_run_cnt <= 4'd0;
    else       r_run_cnt <= w_run_cnt_nxt;
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares the single RAM port between the CPU bus and the read-only video
// line-prefetch engine. One access every three cycles: IDLE (arbitrate and
// load RAM registers), ACCESS (ram_sel high, RAM samples at the end),
// RESP (RAM data valid, completion pulse to the winner).
// Optional macro RAM_ARB_STATS_EN adds 32-bit per-side grant counters.
//
// Handshake: a requester raises cpu_valid / vid_req with stable address and
// data and holds them until it sees its one-cycle cpu_ready / vid_ack pulse;
// read data is valid only during that pulse. Requests are sampled in IDLE
// only, so a requester may drop or replace its request during the pulse.
module ram_port_arbiter #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 32,
  parameter int VID_MAX_RUN = 4
) (
  input  logic                clk_cpu,
  input  logic                reset,
  input  logic                cpu_valid,
  input  logic [DATA_W/8-1:0] cpu_wstrb,
  input  logic [ADDR_W-1:0]   cpu_addr,
  input  logic [DATA_W-1:0]   cpu_wdata,
  output logic                cpu_ready,
  output logic [DATA_W-1:0]   cpu_rdata,
  input  logic                vid_req,
  input  logic [ADDR_W-1:0]   vid_addr,
  output logic                vid_ack,
  output logic [DATA_W-1:0]   vid_rdata,
  output logic                ram_sel,
  output logic [DATA_W/8-1:0] ram_wen,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_wdata,
  input  logic [DATA_W-1:0]   ram_rdata,
  output logic [31:0]         cnt_cpu_grants,
  output logic [31:0]         cnt_vid_grants
);

  import ram_arb_pkg::*;

  localparam int STRB = DATA_W / 8;

  state_e              r_state;
  state_e              w_state_nxt;
  grant_e              r_gnt;
  grant_e              w_sched_gnt;
  logic                w_arb_en;
  logic                r_ram_sel;
  logic [STRB-1:0]     r_ram_wen;
  logic [ADDR_W-1:0]   r_ram_addr;
  logic [DATA_W-1:0]   r_ram_wdata;

  ram_arb_sched #(
    .VID_MAX_RUN (VID_MAX_RUN)
  ) u_sched (
    .clk_cpu   (clk_cpu),
    .reset     (reset),
    .cpu_valid (cpu_valid),
    .vid_req   (vid_req),
    .arb_en    (w_arb_en),
    .gnt       (w_sched_gnt)
  );

  // Next-state logic; arbitration is enabled only while idle.
  always_comb begin
    w_state_nxt = r_state;
    w_arb_en    = 1'b0;
    case (r_state)
      IDLE: begin
        w_arb_en = 1'b1;
        if (w_sched_gnt != GNT_NONE) w_state_nxt = ACCESS;
      end
      ACCESS:  w_state_nxt = RESP;
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register; reset drops any in-flight access.
  always_ff @(posedge clk_cpu or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // RAM output registers and the owner of the in-flight access.
  always_ff @(posedge clk_cpu or posedge reset) begin
    if (reset) begin
      r_ram_sel   <= 1'b0;
      r_ram_wen   <= '0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_gnt       <= GNT_NONE;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_sched_gnt == GNT_CPU) begin
            r_ram_sel   <= 1'b1;
            r_ram_wen   <= cpu_wstrb;
            r_ram_addr  <= cpu_addr;
            r_ram_wdata <= cpu_wdata;
            r_gnt       <= GNT_CPU;
          end else if (w_sched_gnt == GNT_VID) begin
            // Video is read-only: byte enables forced low.
            r_ram_sel   <= 1'b1;
            r_ram_wen   <= '0;
            r_ram_addr  <= vid_addr;
            r_ram_wdata <= '0;
            r_gnt       <= GNT_VID;
          end else begin
            r_ram_sel <= 1'b0;
            r_ram_wen <= '0;
          end
        end
        ACCESS: begin
          r_ram_sel <= 1'b0;
          r_ram_wen <= '0;
        end
        RESP: begin
          r_gnt <= GNT_NONE;
        end
        default: begin
          r_ram_sel <= 1'b0;
          r_ram_wen <= '0;
          r_gnt     <= GNT_NONE;
        end
      endcase
    end
  end

  assign ram_sel   = r_ram_sel;
  assign ram_wen   = r_ram_wen;
  assign ram_addr  = r_ram_addr;
  assign ram_wdata = r_ram_wdata;

  assign cpu_ready = (r_state == RESP) && (r_gnt == GNT_CPU);
  assign vid_ack   = (r_state == RESP) && (r_gnt == GNT_VID);
  assign cpu_rdata = (r_gnt == GNT_CPU) ? ram_rdata : '0;
  assign vid_rdata = (r_gnt == GNT_VID) ? ram_rdata : '0;

`ifdef RAM_ARB_STATS_EN
  logic [31:0] r_cnt_cpu;
  logic [31:0] r_cnt_vid;

  // Grant counters, bumped on each IDLE->ACCESS grant; wrap naturally.
  always_ff @(posedge clk_cpu or posedge reset) begin
    if (reset) begin
      r_cnt_cpu <= 32'd0;
      r_cnt_vid <= 32'd0;
    end else begin
      if (w_arb_en && (w_sched_gnt == GNT_CPU)) r_cnt_cpu <= r_cnt_cpu + 32'd1;
      if (w_arb_en && (w_sched_gnt == GNT_VID)) r_cnt_vid <= r_cnt_vid + 32'd1;
    end
  end

  assign cnt_cpu_grants = r_cnt_cpu;
  assign cnt_vid_grants = r_cnt_vid;
`else
  assign cnt_cpu_grants = 32'd0;
  assign cnt_vid_grants = 32'd0;
`endif

endmodule
